ring_pattern_decoder: RTL and testbench

- Receive-side companion to the 8-bit one-hot ring counter.
- Samples the ring pattern on the fast master clock and decodes it to a binary index.
- Infers shift direction: `dir=0` is left shift (1→2→…→128→1); `dir=1` is right shift (128→64→…→1→128).
- Declares lock after a run of legal steps, and flags and counts illegal patterns or jumps.
- Sits between the ring counter output and the display/check logic. The ring counter advances on a divided clock, so most `mclk` cycles see no change.

---
 rtl/ring_dec_pkg.sv | 20 ++
 rtl/onehot_to_idx.sv | 27 ++
 rtl/ring_pattern_decoder.sv | 134 +++++++++++++
 tb/tb_ring_pattern_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ring_dec_pkg.sv
// Shared types and constants for the ring pattern decoder.
package ring_dec_pkg;

    localparam int DEF_WIDTH = 8;

    // Tracking FSM states; ACQUIRE is the reset state.
    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        LOCKED
    } state_e;

    // Classification of the step between the previous and the new index.
    typedef enum logic [1:0] {
        FWD,
        BWD,
        JUMP
    } step_e;

endpackage

// File: rtl/onehot_to_idx.sv
// Combinational one-hot check and binary index extraction.
module onehot_to_idx #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         pat,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] idx
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] ones;

    // Count set bits and remember the position of the highest one.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pat[i]) begin
                ones = ones + CW'(1);
                idx  = IW'(i);
            end
        end
        valid = (ones == CW'(1));
    end

endmodule

// File: rtl/ring_pattern_decoder.sv
// Decodes a one-hot ring pattern to an index, infers shift direction,
// declares lock after LOCK_STEPS same-direction steps and flags illegal
// patterns or jumps. Define RING_DEC_ERRCNT_EN to build the saturating
// error counter; otherwise err_cnt is tied to zero.
module ring_pattern_decoder
    import ring_dec_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_STEPS = 4,
    parameter int ERR_W      = 8
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pat,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     onehot_ok,
    output logic                     dir,
    output logic                     locked,
    output logic                     step_err,
    output logic [ERR_W-1:0]         err_cnt
);
    localparam int         IW     = $clog2(WIDTH);
    localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

    logic [WIDTH-1:0] pat_q, last_q;
    logic             eval;
    logic             nvalid;
    logic [IW-1:0]    nidx;
    logic [IW-1:0]    idx_inc, idx_dec;
    step_e            step;
    logic             same_dir;
    logic             err_ev;
    logic [3:0]       step_cnt, cnt_inc;
    state_e           state;

    onehot_to_idx #(.WIDTH(WIDTH)) u_dec (
        .pat   (pat_q),
        .valid (nvalid),
        .idx   (nidx)
    );

    assign eval = (pat_q != last_q);

    // Classify the step relative to the last accepted index (mod WIDTH).
    always_comb begin
        idx_inc  = (idx == IW'(WIDTH - 1)) ? '0 : idx + IW'(1);
        idx_dec  = (idx == '0) ? IW'(WIDTH - 1) : idx - IW'(1);
        if (nidx == idx_inc)      step = FWD;
        else if (nidx == idx_dec) step = BWD;
        else                      step = JUMP;
        same_dir = (step == FWD && !dir) || (step == BWD && dir);
        cnt_inc  = (step_cnt < LOCK_N) ? step_cnt + 4'd1 : step_cnt;
        err_ev   = eval && (state != ACQUIRE) && (!nvalid || step == JUMP);
    end

    // Input sampling and tracking FSM with registered outputs.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            pat_q     <= '0;
            last_q    <= '0;
            state     <= ACQUIRE;
            step_cnt  <= '0;
            idx       <= '0;
            onehot_ok <= 1'b0;
            dir       <= 1'b0;
            locked    <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            pat_q    <= pat;
            step_err <= 1'b0;
            if (eval) begin
                last_q    <= pat_q;
                onehot_ok <= nvalid;
                case (state)
                    ACQUIRE: begin
                        // Illegal patterns here are silently ignored.
                        if (nvalid) begin
                            idx      <= nidx;
                            step_cnt <= '0;
                            state    <= TRACK;
                        end
                    end
                    default: begin
                        if (err_ev) begin
                            // A legal jump target is not adopted as reference.
                            step_err <= 1'b1;
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                            step_cnt <= '0;
                        end else if (state == TRACK && step_cnt == '0) begin
                            // First step after acquisition picks the direction.
                            idx      <= nidx;
                            dir      <= (step == BWD);
                            step_cnt <= 4'd1;
                            if (LOCK_N <= 4'd1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (same_dir) begin
                            idx      <= nidx;
                            step_cnt <= cnt_inc;
                            if (cnt_inc >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            // Opposite-direction step is a legal mode switch.
                            idx      <= nidx;
                            dir      <= ~dir;
                            step_cnt <= 4'd1;
                            state    <= TRACK;
                            locked   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

`ifdef RING_DEC_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    // Saturating count of error pulses, updated with step_err.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst)                          err_q <= '0;
        else if (err_ev && err_q != '1)    err_q <= err_q + ERR_W'(1);
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_pattern_decoder.sv
// Scoreboard bench for ring_pattern_decoder: stimulus pushes expected
// responses due two edges later; a negedge monitor pops and compares.
module tb_ring_pattern_decoder;

    logic       mclk = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] pat  = 8'h00;
    logic [2:0] idx;
    logic       onehot_ok, dir, locked, step_err;
    logic [7:0] err_cnt;

    typedef struct {
        int         due;
        logic [2:0] idx;
        logic       ok;
        logic       dir;
        logic       lk;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   e_err  = 0;

    ring_pattern_decoder #(.WIDTH(8), .LOCK_STEPS(4), .ERR_W(8)) dut (
        .mclk      (mclk),
        .rst       (rst),
        .pat       (pat),
        .idx       (idx),
        .onehot_ok (onehot_ok),
        .dir       (dir),
        .locked    (locked),
        .step_err  (step_err),
        .err_cnt   (err_cnt)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ecnt();
`ifdef RING_DEC_ERRCNT_EN
        return (e_err > 255) ? 8'd255 : 8'(e_err);
`else
        return 8'd0;
`endif
    endfunction

    // Drive pat right after an edge; outputs are due two edges later.
    task automatic apply(input logic [7:0] p, input logic [2:0] i, input logic ok,
                         input logic d, input logic lk, input logic er, input int gap);
        exp_t x;
        @(posedge mclk);
        #1;
        pat = p;
        if (er) e_err++;
        x.due = cyc + 2; x.idx = i; x.ok = ok; x.dir = d; x.lk = lk; x.err = er; x.cnt = ecnt();
        sb.push_back(x);
        repeat (gap) @(posedge mclk);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge mclk);
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_idx"}, 32'(idx), 32'd0);
        chk({tag, "_ok"}, 32'(onehot_ok), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_step_err"}, 32'(step_err), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Monitor: compare due responses; step_err must stay low otherwise.
    always @(negedge mclk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("sb_stale", 32'(e.due), 32'(cyc));
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("idx", 32'(idx), 32'(e.idx));
            chk("onehot_ok", 32'(onehot_ok), 32'(e.ok));
            chk("dir", 32'(dir), 32'(e.dir));
            chk("locked", 32'(locked), 32'(e.lk));
            chk("step_err", 32'(step_err), 32'(e.err));
            chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
        end else begin
            chk("step_err_idle", 32'(step_err), 32'd0);
        end
    end

    initial begin
        repeat (3) @(posedge mclk);
        #1;
        chk_reset("reset");
        @(posedge mclk);
        #2;
        rst = 1'b1;

        // Acquire and lock going left, one step every 10 cycles.
        apply(8'h01, 3'd0, 1, 0, 0, 0, 10);
        apply(8'h02, 3'd1, 1, 0, 0, 0, 10);
        apply(8'h04, 3'd2, 1, 0, 0, 0, 10);
        apply(8'h08, 3'd3, 1, 0, 0, 0, 10);
        apply(8'h10, 3'd4, 1, 0, 1, 0, 10);
        // Locked left through the 128 -> 1 wrap.
        apply(8'h20, 3'd5, 1, 0, 1, 0, 3);
        apply(8'h40, 3'd6, 1, 0, 1, 0, 3);
        apply(8'h80, 3'd7, 1, 0, 1, 0, 3);
        apply(8'h01, 3'd0, 1, 0, 1, 0, 3);
        apply(8'h02, 3'd1, 1, 0, 1, 0, 3);
        apply(8'h04, 3'd2, 1, 0, 1, 0, 3);
        apply(8'h08, 3'd3, 1, 0, 1, 0, 3);
        // Mode flip at 8, relock right through the 1 -> 128 wrap.
        apply(8'h04, 3'd2, 1, 1, 0, 0, 3);
        apply(8'h02, 3'd1, 1, 1, 0, 0, 3);
        apply(8'h01, 3'd0, 1, 1, 0, 0, 3);
        apply(8'h80, 3'd7, 1, 1, 1, 0, 3);
        apply(8'h40, 3'd6, 1, 1, 1, 0, 3);
        apply(8'h20, 3'd5, 1, 1, 1, 0, 3);
        apply(8'h10, 3'd4, 1, 1, 1, 0, 3);
        apply(8'h08, 3'd3, 1, 1, 1, 0, 3);
        // Two-hot pattern while locked at 8, then reacquire at 1.
        apply(8'h24, 3'd3, 0, 1, 0, 1, 3);
        apply(8'h01, 3'd0, 1, 1, 0, 0, 3);
        // Lock right down to 2, then jump to 32.
        apply(8'h80, 3'd7, 1, 1, 0, 0, 2);
        apply(8'h40, 3'd6, 1, 1, 0, 0, 2);
        apply(8'h20, 3'd5, 1, 1, 0, 0, 2);
        apply(8'h10, 3'd4, 1, 1, 1, 0, 2);
        apply(8'h08, 3'd3, 1, 1, 1, 0, 2);
        apply(8'h04, 3'd2, 1, 1, 1, 0, 2);
        apply(8'h02, 3'd1, 1, 1, 1, 0, 2);
        apply(8'h20, 3'd1, 1, 1, 0, 1, 2);
        // Back-to-back reacquire/jump pairs drive err_cnt into saturation.
        for (int n = 0; n < 300; n++) begin
            apply(8'h02, 3'd1, 1, 1, 0, 0, 0);
            apply(8'h20, 3'd1, 1, 1, 0, 1, 0);
        end
        // Drop to zero and recover: only the zero pattern is an error.
        apply(8'h02, 3'd1, 1, 1, 0, 0, 2);
        apply(8'h00, 3'd1, 0, 1, 0, 1, 2);
        apply(8'h01, 3'd0, 1, 1, 0, 0, 2);
        // Relock left at 16 ahead of the asynchronous reset.
        apply(8'h02, 3'd1, 1, 0, 0, 0, 2);
        apply(8'h04, 3'd2, 1, 0, 0, 0, 2);
        apply(8'h08, 3'd3, 1, 0, 0, 0, 2);
        apply(8'h10, 3'd4, 1, 0, 1, 0, 2);
        drain();

        // Reset mid-cycle must clear outputs before the next edge.
        @(posedge mclk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        pat = 8'h00;
        repeat (3) @(posedge mclk);
        #2;
        rst = 1'b1;
        repeat (6) @(posedge mclk);
        #1;
        chk_reset("post_release");
        apply(8'h01, 3'd0, 1, 0, 0, 0, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
